// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
// Data-memory responder for the EX/MEM stage. Accepts one load or store per
// transaction, drives a single-beat 64-bit bus request with byte enables and
// lane-shifted store data, and returns the extended load result toward MEM/WB.
//
// Ports
//   clk, rst_n             : clock (rising edge), asynchronous active-low reset
//   mem_read, mem_write    : load / store request from the EX/MEM register
//   funct3                 : size and sign (B,H,W,D,BU,HU,WU)
//   addr, wdata            : byte address and LSB-aligned store data
//   stall_m                : freeze IF/ID/EX/MEM while a transaction is in flight
//   load_valid, load_data  : extended load result, valid for one cycle
//   fault                  : one-cycle pulse for a misaligned or illegal request
//   bus_req ... bus_wdata  : bus request channel (address forced to 8B aligned)
//   bus_gnt                : request accepted by the bus
//   bus_rvalid, bus_rdata  : read response channel
// -----------------------------------------------------------------------------
module lsu_mem_port #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wdata,
   output logic            stall_m,
   output logic            load_valid,
   output logic [XLEN-1:0] load_data,
   output logic            fault,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [7:0]      bus_be,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_gnt,
   input  logic            bus_rvalid,
   input  logic [XLEN-1:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsuStateE;

   lsuStateE         stateR;
   lsuStateE         nextStateS;
   logic             isLoadR;
   logic [2:0]       funct3R;
   logic [XLEN-1:0]  addrR;
   logic [7:0]       beR;
   logic [XLEN-1:0]  wdataR;
   logic [XLEN-1:0]  loadDataR;
   logic             reqPresentS;
   logic             illegalS;
   logic             acceptS;

   // Illegal: both directions, reserved size, unsigned store, or misalignment.
   function automatic logic isIllegal(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [2:0] off);
      logic bad;
      bad = 1'b0;
      if (rd && wr) begin
         bad = 1'b1;
      end else if (f3 == 3'b111) begin
         bad = 1'b1;
      end else if (wr && f3[2]) begin
         bad = 1'b1;
      end else begin
         case (f3[1:0])
            2'b01:   bad = (off[0]   != 1'b0);
            2'b10:   bad = (off[1:0] != 2'b00);
            2'b11:   bad = (off[2:0] != 3'b000);
            default: bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

   function automatic logic [7:0] byteEnable(input logic [2:0] f3, input logic [2:0] off);
      logic [7:0] be;
      case (f3[1:0])
         2'b00:   be = 8'h01 << off;
         2'b01:   be = 8'h03 << off;
         2'b10:   be = 8'h0F << off;
         2'b11:   be = 8'hFF;
         default: be = 8'h00;
      endcase
      return be;
   endfunction

   // Right-align the addressed bytes, then sign- or zero-extend by funct3.
   function automatic logic [XLEN-1:0] extractLoad(input logic [2:0] f3,
                                                   input logic [XLEN-1:0] rdata,
                                                   input logic [2:0] off);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] res;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  res = {{(XLEN-8){sh[7]}},   sh[7:0]};
         3'b001:  res = {{(XLEN-16){sh[15]}}, sh[15:0]};
         3'b010:  res = {{(XLEN-32){sh[31]}}, sh[31:0]};
         3'b011:  res = sh;
         3'b100:  res = {{(XLEN-8){1'b0}},    sh[7:0]};
         3'b101:  res = {{(XLEN-16){1'b0}},   sh[15:0]};
         3'b110:  res = {{(XLEN-32){1'b0}},   sh[31:0]};
         default: res = {XLEN{1'b0}};
      endcase
      return res;
   endfunction

   assign reqPresentS = mem_read | mem_write;
   assign illegalS    = isIllegal(mem_read, mem_write, funct3, addr[2:0]);
   assign acceptS     = (stateR == IDLE) && reqPresentS && !illegalS;

   // FSM state register; reset aborts any in-flight transaction without retry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateR <= IDLE;
      end else begin
         stateR <= nextStateS;
      end
   end

   // Next-state logic; gnt and rvalid only matter in the state that expects them.
   always_comb begin
      nextStateS = stateR;
      case (stateR)
         IDLE: begin
            if (acceptS) nextStateS = REQ;
            else         nextStateS = IDLE;
         end
         REQ: begin
            if (bus_gnt) nextStateS = isLoadR ? WAIT : DONE;
            else         nextStateS = REQ;
         end
         WAIT: begin
            if (bus_rvalid) nextStateS = DONE;
            else            nextStateS = WAIT;
         end
         DONE:    nextStateS = IDLE;
         default: nextStateS = IDLE;
      endcase
   end

   // Request capture at accept and load-result capture on rvalid in WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         isLoadR   <= 1'b0;
         funct3R   <= 3'b000;
         addrR     <= {XLEN{1'b0}};
         beR       <= 8'h00;
         wdataR    <= {XLEN{1'b0}};
         loadDataR <= {XLEN{1'b0}};
      end else begin
         if (acceptS) begin
            isLoadR <= mem_read;
            funct3R <= funct3;
            addrR   <= addr;
            beR     <= byteEnable(funct3, addr[2:0]);
            wdataR  <= wdata << {addr[2:0], 3'b000};
         end
         if ((stateR == WAIT) && bus_rvalid) begin
            loadDataR <= extractLoad(funct3R, bus_rdata, addrR[2:0]);
         end
      end
   end

   // Output decode; stall_m and fault react to the presented request in IDLE.
   always_comb begin
      bus_req    = 1'b0;
      bus_we     = 1'b0;
      bus_addr   = {XLEN{1'b0}};
      bus_be     = 8'h00;
      bus_wdata  = {XLEN{1'b0}};
      load_valid = 1'b0;
      stall_m    = 1'b0;
      fault      = 1'b0;
      case (stateR)
         IDLE: begin
            stall_m = rst_n && acceptS;
            fault   = rst_n && reqPresentS && illegalS;
         end
         REQ: begin
            bus_req   = 1'b1;
            bus_we    = !isLoadR;
            bus_addr  = {addrR[XLEN-1:3], 3'b000};
            bus_be    = beR;
            bus_wdata = wdataR;
            stall_m   = 1'b1;
         end
         WAIT: begin
            stall_m = 1'b1;
         end
         DONE: begin
            load_valid = isLoadR;
         end
         default: begin
            stall_m = 1'b0;
         end
      endcase
   end

   assign load_data = loadDataR;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [7:0]  be;
      logic [63:0] wdata;
   } busTxnT;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        stall_m;
   logic        load_valid;
   logic [63:0] load_data;
   logic        fault;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [7:0]  bus_be;
   logic [63:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [63:0] bus_rdata;

   int          nCompared = 0;
   int          nMismatched = 0;

   busTxnT      busQ[$];
   logic [63:0] loadQ[$];
   int          faultQ[$];

   // responder controls
   logic        respEn = 1'b1;
   int          gntDelay = 0;
   logic [63:0] rdataVal = 64'h0;

   lsu_mem_port #(.XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .addr(addr), .wdata(wdata),
      .stall_m(stall_m), .load_valid(load_valid), .load_data(load_data),
      .fault(fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nCompared++;
      nMismatched++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic logic [63:0] beMask(input logic [7:0] be);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{be[i]}};
      return m;
   endfunction

   task automatic checkAllZero(input string tag);
      check({tag, " stall_m"},    {63'h0, stall_m},    64'h0);
      check({tag, " load_valid"}, {63'h0, load_valid}, 64'h0);
      check({tag, " fault"},      {63'h0, fault},      64'h0);
      check({tag, " bus_req"},    {63'h0, bus_req},    64'h0);
      check({tag, " bus_we"},     {63'h0, bus_we},     64'h0);
      check({tag, " bus_addr"},   bus_addr,            64'h0);
      check({tag, " bus_be"},     {56'h0, bus_be},     64'h0);
      check({tag, " bus_wdata"},  bus_wdata,           64'h0);
      check({tag, " load_data"},  load_data,           64'h0);
   endtask

   // Bus responder: grants after gntDelay REQ cycles, returns data the next cycle.
   initial begin
      logic pendingRead;
      int   gntCnt;
      pendingRead = 1'b0;
      gntCnt      = 0;
      bus_gnt     = 1'b0;
      bus_rvalid  = 1'b0;
      bus_rdata   = 64'h0;
      forever begin
         @(posedge clk);
         #1;
         if (respEn) begin
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (bus_req) begin
               if (gntCnt >= gntDelay) begin
                  bus_gnt     = 1'b1;
                  gntCnt      = 0;
                  pendingRead = !bus_we;
               end else begin
                  gntCnt++;
               end
            end else if (pendingRead) begin
               bus_rvalid  = 1'b1;
               bus_rdata   = rdataVal;
               pendingRead = 1'b0;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a bus request, load result or fault.
   initial begin
      logic        prevReq;
      busTxnT      e;
      busTxnT      cap;
      logic [63:0] expLoad;
      int          dummy;
      prevReq = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_req) begin
            if (!prevReq) begin
               if (busQ.size() == 0) begin
                  failNow("unexpected bus_req");
               end else begin
                  e = busQ.pop_front();
                  check("bus_we",   {63'h0, bus_we}, {63'h0, e.we});
                  check("bus_addr", bus_addr, e.addr);
                  check("bus_be",   {56'h0, bus_be}, {56'h0, e.be});
                  if (e.we) check("bus_wdata", bus_wdata & beMask(e.be), e.wdata & beMask(e.be));
                  cap.we = bus_we; cap.addr = bus_addr; cap.be = bus_be; cap.wdata = bus_wdata;
               end
            end else begin
               check("hold bus_addr", bus_addr, cap.addr);
               check("hold bus_we_be", {55'h0, bus_we, bus_be}, {55'h0, cap.we, cap.be});
               check("hold bus_wdata", bus_wdata, cap.wdata);
            end
         end
         prevReq = bus_req;
         if (load_valid) begin
            if (loadQ.size() == 0) begin
               failNow("unexpected load_valid");
            end else begin
               expLoad = loadQ.pop_front();
               check("load_data", load_data, expLoad);
            end
         end
         if (fault) begin
            if (faultQ.size() == 0) failNow("unexpected fault");
            else dummy = faultQ.pop_front();
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
   endtask

   // Presents a request and holds it until stall_m drops; counts stall cycles.
   task automatic runReq(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                         input int gdly, input logic [63:0] rdat, input logic expFault,
                         input logic [7:0] expBe, input logic [63:0] expWd,
                         input logic [63:0] expLoad, input int expStall);
      busTxnT t;
      int     stallCnt;
      int     cyc;
      logic   done;
      if (expFault) begin
         faultQ.push_back(1);
      end else begin
         t.we = wr; t.addr = a & ~64'h7; t.be = expBe; t.wdata = expWd;
         busQ.push_back(t);
         if (rd) loadQ.push_back(expLoad);
      end
      gntDelay = gdly;
      rdataVal = rdat;
      @(posedge clk);
      #1;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      stallCnt = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         if (stall_m) stallCnt++;
         else         done = 1'b1;
         cyc++;
      end
      if (!done) failNow({name, " timeout"});
      check({name, " stall cycles"}, 64'(stallCnt), 64'(expStall));
   endtask

   initial begin
      rst_n = 1'b0; mem_write = 1'b0; wdata = 64'h0;
      mem_read = 1'b1; funct3 = 3'b011; addr = 64'h0;   // legal request held during reset
      @(negedge clk); checkAllZero("reset0");
      @(negedge clk); checkAllZero("reset1");
      @(posedge clk); #1; rst_n = 1'b1; mem_read = 1'b0;
      idle(2);

      // S1: LB 0x1003
      runReq("LB", 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 0, 64'h0000_0000_8000_0000,
             1'b0, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 3);
      idle(2);
      // S2: SH 0x2006
      runReq("SH", 1'b0, 1'b1, 3'b001, 64'h2006, 64'hBEEF, 0, 64'h0,
             1'b0, 8'hC0, 64'hBEEF_0000_0000_0000, 64'h0, 2);
      idle(2);
      // S3: LWU 0x10 with grant delayed 3 cycles
      runReq("LWU", 1'b1, 1'b0, 3'b110, 64'h10, 64'h0, 3, 64'hDEAD_BEEF_8765_4321,
             1'b0, 8'h0F, 64'h0, 64'h0000_0000_8765_4321, 6);
      idle(3);
      check("load_data hold", load_data, 64'h0000_0000_8765_4321);
      check("load_valid idle", {63'h0, load_valid}, 64'h0);
      // S4: illegal requests
      runReq("LW misaligned", 1'b1, 1'b0, 3'b010, 64'h102, 64'h0, 0, 64'h0,
             1'b1, 8'h00, 64'h0, 64'h0, 0);
      idle(2);
      runReq("read+write", 1'b1, 1'b1, 3'b011, 64'h0, 64'h0, 0, 64'h0,
             1'b1, 8'h00, 64'h0, 64'h0, 0);
      idle(2);
      runReq("store unsigned", 1'b0, 1'b1, 3'b100, 64'h0, 64'h0, 0, 64'h0,
             1'b1, 8'h00, 64'h0, 64'h0, 0);
      idle(1);
      runReq("funct3 111", 1'b1, 1'b0, 3'b111, 64'h0, 64'h0, 0, 64'h0,
             1'b1, 8'h00, 64'h0, 64'h0, 0);
      idle(1);
      runReq("SD misaligned", 1'b0, 1'b1, 3'b011, 64'h4, 64'h0, 0, 64'h0,
             1'b1, 8'h00, 64'h0, 64'h0, 0);
      idle(1);
      // more sizes and lanes
      runReq("LW hi", 1'b1, 1'b0, 3'b010, 64'h104, 64'h0, 1, 64'h8000_0001_0000_0000,
             1'b0, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0001, 4);
      idle(1);
      runReq("LHU", 1'b1, 1'b0, 3'b101, 64'h6, 64'h0, 0, 64'hFFFE_0000_0000_0000,
             1'b0, 8'hC0, 64'h0, 64'h0000_0000_0000_FFFE, 3);
      idle(1);
      runReq("LH", 1'b1, 1'b0, 3'b001, 64'h6, 64'h0, 0, 64'hFFFE_0000_0000_0000,
             1'b0, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 3);
      idle(1);
      runReq("LBU", 1'b1, 1'b0, 3'b100, 64'h7, 64'h0, 0, 64'h9A00_0000_0000_0000,
             1'b0, 8'h80, 64'h0, 64'h0000_0000_0000_009A, 3);
      idle(1);
      runReq("SB", 1'b0, 1'b1, 3'b000, 64'h5, 64'h77, 2, 64'h0,
             1'b0, 8'h20, 64'h0000_7700_0000_0000, 64'h0, 4);
      idle(1);
      runReq("SW", 1'b0, 1'b1, 3'b010, 64'h4, 64'h1122_3344, 0, 64'h0,
             1'b0, 8'hF0, 64'h1122_3344_0000_0000, 64'h0, 2);
      idle(1);
      // S6: back-to-back SD then LD at 0x8
      runReq("SD b2b", 1'b0, 1'b1, 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 0, 64'h0,
             1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 2);
      runReq("LD b2b", 1'b1, 1'b0, 3'b011, 64'h8, 64'h0, 0, 64'hCAFE_F00D_1234_5678,
             1'b0, 8'hFF, 64'h0, 64'hCAFE_F00D_1234_5678, 3);
      idle(2);

      // S5: LD 0x40, reset pulse during WAIT, then a late rvalid
      respEn = 1'b0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      busQ.push_back('{we: 1'b0, addr: 64'h40, be: 8'hFF, wdata: 64'h0});
      @(posedge clk); #1; mem_read = 1'b1; funct3 = 3'b011; addr = 64'h40;
      @(posedge clk); #1; bus_gnt = 1'b1;                       // in REQ
      @(posedge clk); #1; bus_gnt = 1'b0;                       // in WAIT
      @(negedge clk); check("S5 stall in WAIT", {63'h0, stall_m}, 64'h1);
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk); checkAllZero("S5 reset");
      @(posedge clk); #1; rst_n = 1'b1; mem_read = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 64'h1234;
      @(negedge clk);
      check("S5 late rvalid load_valid", {63'h0, load_valid}, 64'h0);
      check("S5 late rvalid stall", {63'h0, stall_m}, 64'h0);
      @(posedge clk); #1; bus_rvalid = 1'b0;
      @(negedge clk);
      check("S5 after load_valid", {63'h0, load_valid}, 64'h0);
      check("S5 after load_data", load_data, 64'h0);
      respEn = 1'b1;
      idle(2);

      check("bus queue drained",   64'(busQ.size()),   64'h0);
      check("load queue drained",  64'(loadQ.size()),  64'h0);
      check("fault queue drained", 64'(faultQ.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Data-memory responder for the EX/MEM request (MemWrite, funct3, ALUResult, WriteData). Drives a 64-bit data bus and returns load_data toward MEM/WB.

Interface
REQ-001 Parameter: XLEN, 64, data/address width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_read  in  1  load request from the EX/MEM register.
- mem_write  in  1  store request from the EX/MEM register (MemWrite).
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- addr  in  XLEN  byte address (ALUResult).
- wdata  in  XLEN  store data (WriteData), LSB-aligned.
- stall_m  out  1  freeze IF/ID/EX/MEM registers.
- load_valid  out  1  load_data valid this cycle.
- load_data  out  XLEN  extended load result.
- fault  out  1  one-cycle pulse for a misaligned or illegal request.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  XLEN  address with bits [2:0] forced to 0.
- bus_be  out  8  byte enables.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data.

Function
REQ-003 The FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-004 A request SHALL be accepted in IDLE when exactly one of mem_read or mem_write is 1 and the request is legal; accept latches funct3, addr, wdata and the direction; next state is REQ.
REQ-005 A request SHALL be illegal when any of these holds:
- mem_read and mem_write are both 1;
- funct3 = 111;
- mem_write with funct3[2] = 1;
- H with addr[0] != 0;
- W with addr[1:0] != 0;
- D with addr[2:0] != 0.
REQ-006 An illegal request SHALL pulse fault for exactly one cycle (the IDLE cycle it is presented), start no bus access and not assert stall_m.
REQ-007 In REQ, bus_req SHALL be 1 and bus_we, bus_addr, bus_be and bus_wdata SHALL be held stable until bus_gnt = 1.
REQ-008 On bus_gnt in REQ, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-009 In WAIT, bus_req SHALL be 0; on bus_rvalid the FSM SHALL register the extracted data into load_data and go to DONE.
REQ-010 In DONE, stall_m SHALL be 0; load_valid SHALL be 1 for loads only; next state is IDLE unconditionally.
REQ-011 stall_m SHALL be combinational: 1 when (IDLE and a legal request is presented), in REQ, or in WAIT; 0 otherwise.
REQ-012 Minimum latency SHALL be 3 cycles (IDLE accept, REQ with gnt, DONE) for stores and 4 cycles for loads with rvalid one cycle after gnt.
REQ-013 Byte enables SHALL use o = addr[2:0]: B = 0x01<<o, H = 0x03<<o, W = 0x0F<<o, D = 0xFF.
REQ-014 bus_wdata SHALL be wdata << (8*o); bytes in lanes outside bus_be are don't-care.
REQ-015 Load extraction SHALL shift bus_rdata right by 8*o, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to XLEN; D passes all 64 bits.
REQ-016 bus_rvalid outside WAIT and bus_gnt outside REQ SHALL be ignored.
REQ-017 load_data SHALL hold its last value when load_valid = 0.
REQ-018 Request inputs presented outside IDLE SHALL be ignored; the pipeline holds them stable while stall_m = 1.

Reset
REQ-019 While rst_n = 0, the FSM SHALL be in IDLE and all outputs SHALL be 0, with load_data = 0.
REQ-020 Reset asserted mid-transaction (REQ or WAIT) SHALL abort immediately with no retry; a late bus_rvalid after release SHALL be ignored per REQ-016.

Verification
REQ-021 Scenario 1: LB at addr 0x1003, bus_rdata 0x0000_0000_8000_0000, gnt in REQ, rvalid next cycle -> bus_addr 0x1000, bus_be 0x08, load_data 0xFFFF_FFFF_FFFF_FF80, load_valid high for 1 cycle, stall_m high for exactly 3 cycles.
REQ-022 Scenario 2: SH at addr 0x2006, wdata 0xBEEF -> bus_we 1, bus_be 0xC0, bus_wdata[63:48] 0xBEEF, no load_valid, stall_m high for exactly 2 cycles.
REQ-023 Scenario 3: LWU at addr 0x10 with bus_rdata 0xDEAD_BEEF_8765_4321, gnt delayed 3 cycles -> bus signals held stable throughout REQ, load_data 0x0000_0000_8765_4321.
REQ-024 Scenario 4: LW at addr 0x102, and separately mem_read = mem_write = 1 -> each gives a single fault pulse, bus_req never 1, stall_m 0.
REQ-025 Scenario 5: LD at addr 0x40, rst_n low for 1 cycle during WAIT, then rvalid 0x1234 -> outputs 0 during reset, state IDLE, load_valid stays 0.
REQ-026 Scenario 6: back-to-back SD 0x8 then LD 0x8 -> second request accepted the cycle after DONE, LD returns the bus data, no lost or duplicated bus_req.
